pheap_front: RTL and testbench

//  Front-end controller for the 31-entry pipelined event min-heap (pheap).

---
 rtl/pheap_front_if.sv | 43 ++++
 rtl/pheap_front.sv | 144 ++++++++++++++
 tb/tb_pheap_front.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pheap_front_if.sv
// Bus bundle between the pheap front-end controller, its event sources,
// the event dispatcher and the pheap itself.
//
// Handshake semantics: a source transfer happens on a rising clock edge when
// src_vld[i] & src_rdy[i] are both high. src_rdy may depend on src_vld in the
// same cycle. A source may withdraw src_vld before being accepted. deq_req is
// a level request. deq_vld is a one-cycle pulse qualifying deq_data and has
// no ready; the dispatcher must always take it.
interface pheap_front_if #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4
);
    logic [NSRC-1:0]       src_vld;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_rdy;
    logic                  deq_req;
    logic                  deq_vld;
    logic [WIDTH-1:0]      deq_data;
    logic                  evt_empty;
    logic                  heap_enq;
    logic                  heap_deq;
    logic [WIDTH-1:0]      heap_data;
    logic [WIDTH-1:0]      heap_out;
    logic                  heap_full;
    logic                  heap_empty;
    logic                  heap_ready;

    // Environment side: sources, dispatcher and the heap status/data.
    modport master (
        output src_vld, src_data, deq_req,
        output heap_out, heap_full, heap_empty, heap_ready,
        input  src_rdy, deq_vld, deq_data, evt_empty,
        input  heap_enq, heap_deq, heap_data
    );

    // Controller side.
    modport slave (
        input  src_vld, src_data, deq_req,
        input  heap_out, heap_full, heap_empty, heap_ready,
        output src_rdy, deq_vld, deq_data, evt_empty,
        output heap_enq, heap_deq, heap_data
    );
endinterface

// File: rtl/pheap_front.sv
// pheap front-end controller.
// Round-robin arbitrates NSRC event producers into heap enqueues and serves
// dispatcher dequeues. Issues at most one heap op every two cycles (ISSUE then
// GAP), never enq and deq together, never enq when full or deq when empty.
// Dequeues win over enqueues, but after MAX_DEQ_RUN consecutive dequeues
// with an enqueue waiting, the enqueue is let through.
module pheap_front #(
    parameter int WIDTH       = 16,
    parameter int NSRC        = 4,
    parameter int MAX_DEQ_RUN = 4,
    localparam int PW         = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pheap_front_if.slave         bus,
    output logic                 dbg_state_o,
    output logic [PW-1:0]        dbg_rr_ptr_o,
    output logic [3:0]           dbg_deq_run_o
);

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_GAP   = 1'b1
    } state_e;

    localparam logic [3:0]    MAX_RUN  = 4'(MAX_DEQ_RUN);
    localparam logic [PW:0]   NSRC_EXT = (PW+1)'(NSRC);
    localparam logic [PW-1:0] LAST_SRC = PW'(NSRC - 1);

    state_e          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [3:0]      deq_run_q;
    logic [3:0]      deq_run_d;
    logic            deq_vld_q;
    logic [WIDTH-1:0] deq_data_q;

    logic            any_vld;
    logic            enq_ok;
    logic            in_issue;
    logic            do_deq;
    logic            do_enq;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     scan_idx;

    // Issue decision. Gated by rst_n so nothing reaches the heap while in reset.
    assign any_vld  = |bus.src_vld;
    assign enq_ok   = any_vld & ~bus.heap_full & bus.heap_ready;
    assign in_issue = rst_n & (state_q == ST_ISSUE);
    assign do_deq   = in_issue & bus.deq_req & ~bus.heap_empty
                    & (~enq_ok | (deq_run_q < MAX_RUN));
    assign do_enq   = in_issue & ~do_deq & enq_ok;

    // Round-robin winner: first valid source at or after rr_ptr, wrapping.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_idx >= NSRC_EXT) begin
                scan_idx = scan_idx - NSRC_EXT;
            end
            if (!found && bus.src_vld[scan_idx[PW-1:0]]) begin
                win   = scan_idx[PW-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer moves just past the granted source; wraps NSRC-1 -> 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (do_enq) begin
            rr_ptr_d = (win == LAST_SRC) ? '0 : win + 1'b1;
        end
    end

    // Dequeue-run counter: counts dequeues that starve a ready enqueue.
    always_comb begin
        deq_run_d = deq_run_q;
        if (in_issue) begin
            if (do_enq || !enq_ok) begin
                deq_run_d = '0;
            end else if (do_deq) begin
                deq_run_d = deq_run_q + 4'd1;
            end
        end
    end

    // Grant and heap data path; heap_data is held at zero unless enqueuing.
    always_comb begin
        bus.src_rdy   = '0;
        bus.heap_data = '0;
        if (do_enq) begin
            bus.src_rdy[win] = 1'b1;
            bus.heap_data    = bus.src_data[int'(win)*WIDTH +: WIDTH];
        end
    end

    assign bus.heap_enq  = do_enq;
    assign bus.heap_deq  = do_deq;
    assign bus.evt_empty = bus.heap_empty;
    assign bus.deq_vld   = deq_vld_q;
    assign bus.deq_data  = deq_data_q;

    assign dbg_state_o   = state_q;
    assign dbg_rr_ptr_o  = rr_ptr_q;
    assign dbg_deq_run_o = deq_run_q;

    // ISSUE/GAP sequencer with registered dequeue result; reset discards any
    // captured dequeue data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ISSUE;
            rr_ptr_q   <= '0;
            deq_run_q  <= '0;
            deq_vld_q  <= 1'b0;
            deq_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            deq_run_q <= deq_run_d;
            deq_vld_q <= do_deq;
            if (do_deq) begin
                deq_data_q <= bus.heap_out;
            end
            case (state_q)
                ST_ISSUE: begin
                    if (do_deq || do_enq) begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_ISSUE;
                end
                default: begin
                    state_q <= ST_ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pheap_front.sv
// Directed testbench for pheap_front with a small behavioural sorted-array
// heap standing in for pheap.
module tb_pheap_front;
    localparam int WIDTH = 16;
    localparam int NSRC  = 4;
    localparam int MAXR  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pheap_front_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();

    logic       dbg_state;
    logic [1:0] dbg_rr;
    logic [3:0] dbg_run;

    pheap_front #(.WIDTH(WIDTH), .NSRC(NSRC), .MAX_DEQ_RUN(MAXR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .dbg_state_o   (dbg_state),
        .dbg_rr_ptr_o  (dbg_rr),
        .dbg_deq_run_o (dbg_run)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Heap model: ascending sorted array, updated with NBAs on the clock edge.
    logic [WIDTH-1:0] mem [0:31] = '{default: '0};
    int               cnt = 0;
    logic [WIDTH-1:0] m_t [0:31];
    int               m_n;
    int               m_p;
    logic             ready_r = 1'b1;

    assign bus.heap_out   = mem[0];
    assign bus.heap_full  = (cnt == 31);
    assign bus.heap_empty = (cnt == 0);
    assign bus.heap_ready = ready_r;

    always @(posedge clk) begin
        m_t = mem;
        m_n = cnt;
        if (bus.heap_enq && m_n < 31) begin
            m_p = m_n;
            while (m_p > 0 && m_t[m_p-1] > bus.heap_data) begin
                m_t[m_p] = m_t[m_p-1];
                m_p--;
            end
            m_t[m_p] = bus.heap_data;
            m_n++;
        end
        if (bus.heap_deq && m_n > 0) begin
            for (int i = 0; i < 31; i++) m_t[i] = m_t[i+1];
            m_n--;
        end
        mem <= m_t;
        cnt <= m_n;
    end

    task automatic set_src(input int i, input int val);
        bus.src_data[i*WIDTH +: WIDTH] = WIDTH'(val);
    endtask

    // Wait (bounded) for an ISSUE cycle with idle inputs.
    task automatic sync_issue();
        int k;
        k = 0;
        @(negedge clk); #1;
        while (dbg_state !== 1'b0 && k < 4) begin
            @(negedge clk); #1;
            k++;
        end
        n_tests++;
        if (dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_issue state=%b exp=0", dbg_state);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.deq_req = 1'b1;
        while (cnt != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        bus.deq_req = 1'b0;
        n_tests++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL drain cnt=%0d exp=0", cnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.src_vld = 4'hF;
        bus.deq_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (bus.heap_enq !== 1'b0) begin n_fail++; $display("FAIL rst_heap_enq got=%b exp=0", bus.heap_enq); end
        n_tests++; if (bus.heap_deq !== 1'b0) begin n_fail++; $display("FAIL rst_heap_deq got=%b exp=0", bus.heap_deq); end
        n_tests++; if (bus.src_rdy !== 4'h0) begin n_fail++; $display("FAIL rst_src_rdy got=%h exp=0", bus.src_rdy); end
        n_tests++; if (bus.deq_vld !== 1'b0) begin n_fail++; $display("FAIL rst_deq_vld got=%b exp=0", bus.deq_vld); end
        n_tests++; if (bus.deq_data !== 16'h0) begin n_fail++; $display("FAIL rst_deq_data got=%h exp=0", bus.deq_data); end
        n_tests++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_state got=%b exp=0", dbg_state); end
        n_tests++; if (dbg_rr !== 2'd0) begin n_fail++; $display("FAIL rst_rr got=%0d exp=0", dbg_rr); end
        n_tests++; if (dbg_run !== 4'd0) begin n_fail++; $display("FAIL rst_run got=%0d exp=0", dbg_run); end
        bus.src_vld = 4'h0;
        bus.deq_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int         dat [4] = '{40, 30, 20, 10};
        logic [3:0] vld;
        logic [3:0] exp_rdy;
        logic       exp_en;
        logic [15:0] exp_data;
        sync_issue();
        vld = 4'hF;
        for (int i = 0; i < 4; i++) set_src(i, dat[i]);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.src_vld = vld;
            #1;
            exp_en   = (c % 2 == 0);
            exp_rdy  = exp_en ? 4'(1 << (c / 2)) : 4'h0;
            exp_data = exp_en ? 16'(dat[c/2]) : 16'h0;
            n_tests++; if (bus.heap_enq !== exp_en) begin n_fail++; $display("FAIL rr_enq c=%0d got=%b exp=%b", c, bus.heap_enq, exp_en); end
            n_tests++; if (bus.src_rdy !== exp_rdy) begin n_fail++; $display("FAIL rr_rdy c=%0d got=%h exp=%h", c, bus.src_rdy, exp_rdy); end
            n_tests++; if (bus.heap_data !== exp_data) begin n_fail++; $display("FAIL rr_data c=%0d got=%0d exp=%0d", c, bus.heap_data, exp_data); end
            vld = vld & ~exp_rdy;
        end
        @(negedge clk);
        bus.src_vld = 4'h0;
        #1;
        n_tests++; if (dbg_rr !== 2'd0) begin n_fail++; $display("FAIL rr_ptr_wrap got=%0d exp=0", dbg_rr); end
        n_tests++; if (cnt != 4) begin n_fail++; $display("FAIL rr_count got=%0d exp=4", cnt); end
        n_tests++; if (bus.heap_out !== 16'd10) begin n_fail++; $display("FAIL rr_min got=%0d exp=10", bus.heap_out); end
    endtask

    task automatic test_deq_order();
        logic exp_deq;
        sync_issue();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.deq_req = 1'b1;
            #1;
            exp_deq = (c % 2 == 0);
            n_tests++; if (bus.heap_deq !== exp_deq) begin n_fail++; $display("FAIL dq_heap_deq c=%0d got=%b exp=%b", c, bus.heap_deq, exp_deq); end
            n_tests++; if (bus.deq_vld !== !exp_deq) begin n_fail++; $display("FAIL dq_vld c=%0d got=%b exp=%b", c, bus.deq_vld, !exp_deq); end
            if (!exp_deq) begin
                n_tests++;
                if (bus.deq_data !== 16'(10 * (c / 2 + 1))) begin
                    n_fail++;
                    $display("FAIL dq_data c=%0d got=%0d exp=%0d", c, bus.deq_data, 10 * (c / 2 + 1));
                end
            end
        end
        @(negedge clk);
        bus.deq_req = 1'b0;
        #1;
        n_tests++; if (bus.evt_empty !== 1'b1) begin n_fail++; $display("FAIL dq_empty got=%b exp=1", bus.evt_empty); end
    endtask

    task automatic test_full();
        int k;
        sync_issue();
        @(negedge clk);
        bus.src_vld = 4'b0001;
        set_src(0, 100);
        k = 0;
        while (cnt < 31 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        #1;
        n_tests++; if (cnt != 31) begin n_fail++; $display("FAIL full_count got=%0d exp=31", cnt); end
        n_tests++; if (bus.heap_enq !== 1'b0) begin n_fail++; $display("FAIL full_no_enq got=%b exp=0", bus.heap_enq); end
        @(negedge clk);
        bus.src_vld = 4'b0100;
        set_src(2, 5);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (bus.src_rdy !== 4'h0) begin n_fail++; $display("FAIL full_bp c=%0d got=%h exp=0", c, bus.src_rdy); end
            @(negedge clk);
        end
        bus.deq_req = 1'b1;
        #1;
        n_tests++; if (bus.heap_deq !== 1'b1) begin n_fail++; $display("FAIL full_deq got=%b exp=1", bus.heap_deq); end
        n_tests++; if (bus.src_rdy !== 4'h0) begin n_fail++; $display("FAIL full_rdy_deq got=%h exp=0", bus.src_rdy); end
        @(negedge clk);
        bus.deq_req = 1'b0;
        #1;
        n_tests++; if (bus.deq_vld !== 1'b1) begin n_fail++; $display("FAIL full_deq_vld got=%b exp=1", bus.deq_vld); end
        n_tests++; if (bus.deq_data !== 16'd100) begin n_fail++; $display("FAIL full_deq_data got=%0d exp=100", bus.deq_data); end
        n_tests++; if (bus.src_rdy !== 4'h0) begin n_fail++; $display("FAIL full_rdy_gap got=%h exp=0", bus.src_rdy); end
        @(negedge clk);
        #1;
        n_tests++; if (bus.heap_enq !== 1'b1) begin n_fail++; $display("FAIL full_enq_after got=%b exp=1", bus.heap_enq); end
        n_tests++; if (bus.src_rdy !== 4'b0100) begin n_fail++; $display("FAIL full_rdy_after got=%h exp=4", bus.src_rdy); end
        n_tests++; if (bus.heap_data !== 16'd5) begin n_fail++; $display("FAIL full_data_after got=%0d exp=5", bus.heap_data); end
        @(negedge clk);
        bus.src_vld = 4'h0;
        #1;
        n_tests++; if (dbg_rr !== 2'd3) begin n_fail++; $display("FAIL full_rr got=%0d exp=3", dbg_rr); end
    endtask

    task automatic test_back_to_back();
        logic exp_deq;
        logic prev_deq;
        sync_issue();
        @(negedge clk);
        bus.src_vld = 4'b0001;
        set_src(0, 50);
        repeat (15) @(negedge clk);
        n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL b2b_preload got=%0d exp=8", cnt); end
        prev_deq = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            set_src(0, 60);
            bus.deq_req = 1'b1;
            #1;
            n_tests++;
            if (bus.heap_enq === 1'b1 && bus.heap_deq === 1'b1) begin
                n_fail++;
                $display("FAIL b2b_excl c=%0d got=enq&deq exp=one", c);
            end
            if (c % 2 == 0) begin
                exp_deq = ((c / 2) % 5 != 4);
                n_tests++; if (bus.heap_deq !== exp_deq) begin n_fail++; $display("FAIL b2b_deq c=%0d got=%b exp=%b", c, bus.heap_deq, exp_deq); end
                n_tests++; if (bus.heap_enq !== !exp_deq) begin n_fail++; $display("FAIL b2b_enq c=%0d got=%b exp=%b", c, bus.heap_enq, !exp_deq); end
                prev_deq = exp_deq;
            end else begin
                n_tests++; if (bus.deq_vld !== prev_deq) begin n_fail++; $display("FAIL b2b_vld c=%0d got=%b exp=%b", c, bus.deq_vld, prev_deq); end
            end
        end
        @(negedge clk);
        bus.src_vld = 4'h0;
        bus.deq_req = 1'b0;
        drain();
    endtask

    task automatic test_deq_empty();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.deq_req = 1'b1;
            #1;
            n_tests++; if (bus.heap_deq !== 1'b0) begin n_fail++; $display("FAIL empty_deq c=%0d got=%b exp=0", c, bus.heap_deq); end
            n_tests++; if (bus.deq_vld !== 1'b0) begin n_fail++; $display("FAIL empty_vld c=%0d got=%b exp=0", c, bus.deq_vld); end
        end
        @(negedge clk);
        bus.src_vld = 4'b0010;
        set_src(1, 7);
        #1;
        n_tests++; if (bus.heap_enq !== 1'b1) begin n_fail++; $display("FAIL empty_enq got=%b exp=1", bus.heap_enq); end
        n_tests++; if (bus.src_rdy !== 4'b0010) begin n_fail++; $display("FAIL empty_rdy got=%h exp=2", bus.src_rdy); end
        n_tests++; if (bus.heap_data !== 16'd7) begin n_fail++; $display("FAIL empty_hdata got=%0d exp=7", bus.heap_data); end
        @(negedge clk);
        bus.src_vld = 4'h0;
        #1;
        n_tests++; if (bus.heap_deq !== 1'b0) begin n_fail++; $display("FAIL empty_gap got=%b exp=0", bus.heap_deq); end
        @(negedge clk);
        #1;
        n_tests++; if (bus.heap_deq !== 1'b1) begin n_fail++; $display("FAIL empty_deq7 got=%b exp=1", bus.heap_deq); end
        @(negedge clk);
        bus.deq_req = 1'b0;
        #1;
        n_tests++; if (bus.deq_vld !== 1'b1) begin n_fail++; $display("FAIL empty_vld7 got=%b exp=1", bus.deq_vld); end
        n_tests++; if (bus.deq_data !== 16'd7) begin n_fail++; $display("FAIL empty_data7 got=%0d exp=7", bus.deq_data); end
        // heap_ready low blocks enqueue
        @(negedge clk);
        ready_r = 1'b0;
        bus.src_vld = 4'b0001;
        set_src(0, 20);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (bus.heap_enq !== 1'b0) begin n_fail++; $display("FAIL nrdy_enq c=%0d got=%b exp=0", c, bus.heap_enq); end
            n_tests++; if (bus.src_rdy !== 4'h0) begin n_fail++; $display("FAIL nrdy_rdy c=%0d got=%h exp=0", c, bus.src_rdy); end
            @(negedge clk);
        end
        ready_r = 1'b1;
        #1;
        n_tests++; if (bus.heap_enq !== 1'b1) begin n_fail++; $display("FAIL rdy_enq got=%b exp=1", bus.heap_enq); end
        n_tests++; if (bus.src_rdy !== 4'b0001) begin n_fail++; $display("FAIL rdy_rdy got=%h exp=1", bus.src_rdy); end
        @(negedge clk);
        bus.src_vld = 4'h0;
    endtask

    task automatic test_reset_mid_op();
        sync_issue();
        @(negedge clk);
        bus.src_vld = 4'b1000;
        set_src(3, 9);
        #1;
        n_tests++; if (bus.src_rdy !== 4'b1000) begin n_fail++; $display("FAIL mid_rdy3 got=%h exp=8", bus.src_rdy); end
        @(negedge clk);
        bus.src_vld = 4'h0;
        #1;
        n_tests++; if (dbg_rr !== 2'd0) begin n_fail++; $display("FAIL mid_rr_wrap got=%0d exp=0", dbg_rr); end
        @(negedge clk);
        bus.deq_req = 1'b1;
        #1;
        n_tests++; if (bus.heap_deq !== 1'b1) begin n_fail++; $display("FAIL mid_deq got=%b exp=1", bus.heap_deq); end
        @(negedge clk);
        bus.deq_req = 1'b0;
        #1;
        n_tests++; if (bus.deq_vld !== 1'b1) begin n_fail++; $display("FAIL mid_vld_pre got=%b exp=1", bus.deq_vld); end
        n_tests++; if (bus.deq_data !== 16'd9) begin n_fail++; $display("FAIL mid_data_pre got=%0d exp=9", bus.deq_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.deq_vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld_rst got=%b exp=0", bus.deq_vld); end
        n_tests++; if (bus.deq_data !== 16'd0) begin n_fail++; $display("FAIL mid_data_rst got=%0d exp=0", bus.deq_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL mid_state got=%b exp=0", dbg_state); end
        n_tests++; if (dbg_rr !== 2'd0) begin n_fail++; $display("FAIL mid_rr got=%0d exp=0", dbg_rr); end
        n_tests++; if (dbg_run !== 4'd0) begin n_fail++; $display("FAIL mid_run got=%0d exp=0", dbg_run); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_vld  = '0;
        bus.src_data = '0;
        bus.deq_req  = 1'b0;
        test_reset();
        test_round_robin();
        test_deq_order();
        test_full();
        drain();
        test_back_to_back();
        test_deq_empty();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
